// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions used by the pipeline control blocks.
package cpu_types_pkg;

  // Pipeline sequencing controller states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hazard_state_t;

  // Architectural register index.
  typedef logic [4:0] regbits_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: latch enables/flushes for the five-stage
// datapath, halt tracking and saturating stall/flush performance counters.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  regbits_t         ex_rt,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state_q, state_d;
  logic          dwait_need;
  logic          load_use;
  logic          stall_inc;
  logic          flush_inc;

  assign dwait_need = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use   = ex_dREN & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // Mealy control: priority-ordered hazard resolution for the current cycle.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    flush_inc   = 1'b0;

    if ((state_q == HALT) || (wb_halt && (state_q == RUN))) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = HALT;
    end else if (dwait_need) begin
      // Front end and EX/MEM freeze; MEM/WB keeps loading the MEM bubble.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      state_d  = DWAIT;
    end else begin
      state_d = RUN;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (load_use || !ihit) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
        flush_inc  = 1'b1;
      end
    end
  end

  // HALT cycles are idle, not stalls.
  assign stall_inc = ~pc_en & (state_q != HALT);

  // State register with asynchronous reset back to RUN.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign halted = (state_q == HALT);

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (CLK),
    .rst_n(nRST),
    .inc  (stall_inc),
    .clear(1'b0),
    .count(stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (CLK),
    .rst_n(nRST),
    .inc  (flush_inc),
    .clear(1'b0),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        id_uses_rt, ex_branch_taken, id_jump, wb_halt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(
    .CNT_W(16)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .dhit           (dhit),
    .mem_dREN       (mem_dREN),
    .mem_dWEN       (mem_dWEN),
    .ex_dREN        (ex_dREN),
    .ex_rt          (ex_rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .ex_branch_taken(ex_branch_taken),
    .id_jump        (id_jump),
    .wb_halt        (wb_halt),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .halted         (halted),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  wire [4:0] ens = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  wire [2:0] fls = {ifid_flush, idex_flush, exmem_flush};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; ex_dREN = 1'b0;
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_branch_taken = 1'b0; id_jump = 1'b0; wb_halt = 1'b0;
  endtask

  // Advance one clock; inputs then change 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #12;
    check("reset_en", 32'(ens), 32'h1f);
    check("reset_fl", 32'(fls), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    check("reset_stall", 32'(stall_cnt), 32'h0);
    check("reset_flush", 32'(flush_cnt), 32'h0);
    nRST = 1'b1;
    step();

    // Default RUN behaviour.
    #1 check("run_en", 32'(ens), 32'h1f);
    check("run_fl", 32'(fls), 32'h0);

    // Load-use on rs.
    ex_dREN = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1 check("lu_rs_en", 32'(ens), 32'b00111);
    check("lu_rs_fl", 32'(fls), 32'b010);
    step();
    ex_dREN = 1'b0;
    #1 check("lu_clear_en", 32'(ens), 32'h1f);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // $zero destination never stalls.
    ex_dREN = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1 check("lu_zero_en", 32'(ens), 32'h1f);
    check("lu_zero_fl", 32'(fls), 32'h0);
    step();
    check("lu_zero_cnt", 32'(stall_cnt), 32'd1);

    // rt match only counts when the ID instruction reads rt.
    ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
    #1 check("lu_rt_unused_en", 32'(ens), 32'h1f);
    id_uses_rt = 1'b1;
    #1 check("lu_rt_en", 32'(ens), 32'b00111);
    step();
    idle();
    check("lu_rt_cnt", 32'(stall_cnt), 32'd2);

    // Fetch miss.
    ihit = 1'b0;
    #1 check("imiss_en", 32'(ens), 32'b00111);
    check("imiss_fl", 32'(fls), 32'b010);
    step();
    ihit = 1'b1;
    check("imiss_cnt", 32'(stall_cnt), 32'd3);

    // Jump.
    id_jump = 1'b1;
    #1 check("jump_en", 32'(ens), 32'h1f);
    check("jump_fl", 32'(fls), 32'b100);
    step();
    id_jump = 1'b0;
    check("jump_cnt", 32'(flush_cnt), 32'd1);

    // Asynchronous reset away from any edge.
    #2 nRST = 1'b0;
    #1 check("async_rst_stall", 32'(stall_cnt), 32'd0);
    check("async_rst_flush", 32'(flush_cnt), 32'd0);
    nRST = 1'b1;
    step();

    // Store waiting three cycles on dmem.
    mem_dWEN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("dwait_en%0d", i), 32'(ens), 32'b00001);
      check($sformatf("dwait_fl%0d", i), 32'(fls), 32'h0);
      step();
    end
    dhit = 1'b1;
    #1 check("dhit_en", 32'(ens), 32'h1f);
    step();
    idle();
    check("dwait_cnt", 32'(stall_cnt), 32'd3);

    // Branch beats load-use.
    ex_branch_taken = 1'b1; ex_dREN = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1 check("br_lu_en", 32'(ens), 32'h1f);
    check("br_lu_fl", 32'(fls), 32'b110);
    step();
    idle();
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd3);

    // DWAIT beats branch.
    ex_branch_taken = 1'b1; mem_dREN = 1'b1; dhit = 1'b0;
    #1 check("br_dwait_en", 32'(ens), 32'b00001);
    check("br_dwait_fl", 32'(fls), 32'h0);
    step();
    dhit = 1'b1;
    #1 check("br_after_wait_fl", 32'(fls), 32'b110);
    step();
    idle();
    check("br_dwait_stall", 32'(stall_cnt), 32'd4);
    check("br_dwait_flush", 32'(flush_cnt), 32'd2);

    // Halt.
    wb_halt = 1'b1;
    #1 check("halt_en", 32'(ens), 32'h0);
    check("halt_fl", 32'(fls), 32'h0);
    check("halt_pre", 32'(halted), 32'h0);
    step();
    wb_halt = 1'b0;
    check("halted", 32'(halted), 32'h1);
    for (int i = 0; i < 3; i++) step();
    check("halted_sticky", 32'(halted), 32'h1);
    check("halt_hold_en", 32'(ens), 32'h0);
    check("halt_stall", 32'(stall_cnt), 32'd5);
    #2 nRST = 1'b0;
    #1 check("halt_rst", 32'(halted), 32'h0);
    check("halt_rst_stall", 32'(stall_cnt), 32'd0);
    check("halt_rst_flush", 32'(flush_cnt), 32'd0);
    check("halt_rst_en", 32'(ens), 32'h1f);
    nRST = 1'b1;
    step();

    // Saturation.
    ihit = 1'b0;
    for (int i = 0; i < 65541; i++) step();
    check("stall_sat", 32'(stall_cnt), 32'hffff);
    ihit = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage datapath. Owns the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. Resolves load-use hazards, taken-branch and jump redirects, instruction-fetch misses, data-memory waits and halt. Keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 16, width of the performance counters
- CLK  in  1  system clock
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction memory returned valid instruction this cycle
- dhit  in  1  data memory completed the MEM-stage access this cycle
- mem_dREN, mem_dWEN  in  1 each  EX/MEM latch holds a load/store
- ex_dREN  in  1  ID/EX latch holds a load
- ex_rt  in  5  destination register of the load in ID/EX
- id_rs, id_rt  in  5 each  source registers of the instruction in IF/ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch)
- ex_branch_taken  in  1  branch in EX resolved taken
- id_jump  in  1  J/JAL/JR decoded in ID
- wb_halt  in  1  halt instruction in MEM/WB
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch load enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble instead of input
- halted  out  1  registered, sticky halt
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters

## Operation
- FSM states: RUN, DWAIT, HALT. Reset: RUN, halted=0, both counters 0.
- Enables and flushes are Mealy outputs of state plus inputs, so they act in the same cycle as the hazard. Default in RUN with no hazard: every enable is 1 and every flush is 0.
- Conditions are listed in priority order. The first match decides.
- 1. HALT state, or wb_halt in RUN: all enables 0, all flushes 0. Next state is HALT, halted=1. HALT is left only by nRST.
- 2. DWAIT needed, i.e. (mem_dREN|mem_dWEN) & !dhit, in RUN or DWAIT:
  - pc_en, ifid_en, idex_en and exmem_en are 0.
  - memwb_en=1 with the MEM/WB bubble driven by the MEM stage valid=0.
  - Next state is DWAIT. DWAIT returns to RUN in the cycle dhit=1; that cycle uses the normal RUN rules below.
- 3. ex_branch_taken: pc_en=1 (target load), ifid_flush=1, idex_flush=1. flush_cnt increments.
- 4. Load-use, i.e. ex_dREN & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)): pc_en=0, ifid_en=0, idex_flush=1.
- 5. !ihit: pc_en=0, ifid_en=0, idex_flush=1 (fetch bubble). Downstream latches advance.
- 6. id_jump (with ihit): pc_en=1, ifid_flush=1. flush_cnt increments.
- stall_cnt increments on every cycle with pc_en=0, except in the HALT state.
- Both counters saturate at all-ones and never wrap.
- When a flush and an enable apply to the same latch, the flush wins: the latch loads zeros.

## Timing
- Zero-cycle control latency: a hazard detected in cycle N drives controls in cycle N. State and counters update at the CLK edge ending cycle N.
- Load-use inserts exactly one bubble. The next cycle the load sits in EX/MEM and the condition clears.
- Data-memory wait length = cycles until dhit. The first dhit cycle is not counted as a stall unless a lower-priority rule stalls.
- Branch and DWAIT in the same cycle: DWAIT wins. The branch stays in EX because idex_en=0 and is re-evaluated after the wait.
- Reset asserted mid-stall returns to RUN immediately and asynchronously. All outputs go to RUN defaults and the counters go to 0.

## Structure
- The shared cpu_types_pkg gets:
  - hazard_state_t enum {RUN, DWAIT, HALT}
  - regbits_t (5-bit) for register indices
- Sub-module sat_counter (parameter W; inputs inc, clear; output count) is instantiated twice.
- Hazard compare logic stays inline.

## Test plan
- Load-use: lw $5 in EX, ID add uses rs=5 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
- ex_rt=0 with a matching id_rs=0 → no stall; all enables 1.
- Store in MEM, dhit low for 3 cycles then high → 3 cycles of frozen front-end in DWAIT, RUN on the dhit cycle; stall_cnt=3.
- ex_branch_taken together with a load-use match → branch wins: ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1.
- wb_halt=1 → from that cycle all enables 0; halted=1 next edge and stays 1 with wb_halt=0. nRST low mid-halt clears halted and the counters asynchronously.
- Force 2^16+5 stall cycles → stall_cnt holds 16'hFFFF.
